// File: rtl/spi_pkg.sv
// Shared defaults and state encoding for the SPI mode-0 slave.
package spi_pkg;

  localparam int unsigned DataWDefault    = 8;
  localparam int unsigned SyncStagesMin   = 2;
  localparam logic [7:0]  IdleByteDefault = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StShift
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, with registered edge pulses.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int unsigned Stages   = SyncStagesMin,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;
  logic              level;

  assign level = sync_q[Stages-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetVal}};
      prev_q <= ResetVal;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      prev_q <= level;
      rise_q <= level & ~prev_q;
      fall_q <= ~level & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave, MSB first, with all SPI pins oversampled in the system clock domain.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int unsigned      DataW      = DataWDefault,
  parameter int unsigned      SyncStages = SyncStagesMin,
  parameter logic [DataW-1:0] IdleByte   = DataW'(IdleByteDefault)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ncs_i,
  input  logic             sclk_i,
  input  logic             mosi_i,
  output logic             miso_o,
  output logic             miso_oe_o,
  input  logic [DataW-1:0] tx_din_i,
  input  logic             tx_empty_i,
  output logic             tx_rd_o,
  output logic [DataW-1:0] rx_dout_o,
  output logic             rx_wr_o,
  input  logic             rx_full_i,
  output logic             overrun_o,
  output logic             underrun_o,
  output logic             busy_o
);

  localparam int unsigned     Stages  = (SyncStages < SyncStagesMin) ? SyncStagesMin : SyncStages;
  localparam int unsigned     CntW    = (DataW > 2) ? $clog2(DataW) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DataW - 1);

  logic ncs_rise, ncs_fall, sclk_rise, sclk_fall, mosi_s;
  logic [Stages-1:0] mosi_sync_q;

  spi_sync_edge #(.Stages(Stages), .ResetVal(1'b1)) u_ncs_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (ncs_i),
    .rise_o (ncs_rise),
    .fall_o (ncs_fall)
  );

  spi_sync_edge #(.Stages(Stages), .ResetVal(1'b0)) u_sclk_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (sclk_i),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  assign mosi_s = mosi_sync_q[Stages-1];

  spi_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // Only the DataW-1 oldest bits need storing; the last bit joins on completion.
  logic [DataW-2:0] rx_q, rx_d;
  logic [DataW-1:0] tx_q, tx_d;
  logic [DataW-1:0] rx_dout_q, rx_dout_d;
  logic             rx_wr_q, rx_wr_d;
  logic             overrun_q, overrun_d;
  logic             load, tx_rd, underrun;
  logic [DataW-1:0] rx_byte;

  assign rx_byte = {rx_q, mosi_s};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    rx_dout_d = rx_dout_q;
    rx_wr_d   = 1'b0;
    overrun_d = 1'b0;
    load      = 1'b0;
    tx_rd     = 1'b0;
    underrun  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (ncs_fall) state_d = StSelect;
      end
      StSelect: begin
        load    = 1'b1;
        state_d = StShift;
      end
      StShift: begin
        if (sclk_rise) begin
          rx_d = rx_byte[DataW-2:0];
          if (cnt_q == LastBit) begin
            cnt_d = '0;
            if (rx_full_i) begin
              overrun_d = 1'b1;
            end else begin
              rx_wr_d   = 1'b1;
              rx_dout_d = rx_byte;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (sclk_fall && !ncs_rise) begin
          if (cnt_q == '0) load = 1'b1;
          else tx_d = {tx_q[DataW-2:0], 1'b0};
        end
        // A completing byte is still written even if NCS rises in the same cycle.
        if (ncs_rise) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      if (!tx_empty_i) begin
        tx_d  = tx_din_i;
        tx_rd = 1'b1;
      end else begin
        tx_d     = IdleByte;
        underrun = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mosi_sync_q <= '0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= IdleByte;
      rx_dout_q   <= '0;
      rx_wr_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[Stages-2:0], mosi_i};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rx_dout_q   <= rx_dout_d;
      rx_wr_q     <= rx_wr_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign miso_oe_o  = busy_o;
  assign miso_o     = busy_o & tx_q[DataW-1];
  assign tx_rd_o    = tx_rd;
  assign underrun_o = underrun;
  assign rx_wr_o    = rx_wr_q;
  assign rx_dout_o  = rx_dout_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: an SPI master task, FIFO models and a per-cycle checker.
module tb_spi_slave_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ncs = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, tx_rd, rx_wr, overrun, underrun, busy;
  logic [7:0] tx_din = 8'h00;
  logic       tx_empty = 1'b1;
  logic [7:0] rx_dout;
  logic       rx_full = 1'b0;

  spi_slave_core u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ncs_i      (ncs),
    .sclk_i     (sclk),
    .mosi_i     (mosi),
    .miso_o     (miso),
    .miso_oe_o  (miso_oe),
    .tx_din_i   (tx_din),
    .tx_empty_i (tx_empty),
    .tx_rd_o    (tx_rd),
    .rx_dout_o  (rx_dout),
    .rx_wr_o    (rx_wr),
    .rx_full_i  (rx_full),
    .overrun_o  (overrun),
    .underrun_o (underrun),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         rise8_cyc = 0;
  int         ncs_hi_cnt = 0;
  int         ncs_lo_cnt = 0;
  int         n_txrd = 0;
  int         n_under = 0;
  int         n_over = 0;
  bit         pop_pend = 1'b0;
  logic [7:0] tx_fifo[$];
  logic [7:0] exp_rx[$];
  logic [7:0] mosi_q[$];
  bit         full_q[$];
  logic [7:0] last_rx = 8'h00;
  logic [7:0] last_miso = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ncs) begin
      ncs_hi_cnt <= ncs_hi_cnt + 1;
      ncs_lo_cnt <= 0;
    end else begin
      ncs_lo_cnt <= ncs_lo_cnt + 1;
      ncs_hi_cnt <= 0;
    end
  end

  // FIFO models and the per-cycle checker; pops land after the edge that consumed the head.
  always @(negedge clk) begin
    if (pop_pend) begin
      if (tx_fifo.size() > 0) void'(tx_fifo.pop_front());
      pop_pend = 1'b0;
    end
    tx_empty = (tx_fifo.size() == 0);
    tx_din   = tx_empty ? 8'h00 : tx_fifo[0];
    if (rst_n) begin
      if (tx_rd) begin
        n_txrd++;
        pop_pend = 1'b1;
      end
      if (underrun) n_under++;
      if (overrun) n_over++;
      if (rx_wr) begin
        last_rx = rx_dout;
        if (exp_rx.size() == 0) begin
          check("rx_wr_unexpected", 32'd1, 32'd0);
        end else begin
          check("rx_dout", {24'd0, rx_dout}, {24'd0, exp_rx.pop_front()});
          check("rx_latency", cyc - rise8_cyc, 32'd4);
        end
      end
      if (!miso_oe) check("miso_idle", {31'd0, miso}, 32'd0);
      if (ncs_hi_cnt >= 6) begin
        check("busy_deselected", {31'd0, busy}, 32'd0);
        check("miso_oe_deselected", {31'd0, miso_oe}, 32'd0);
      end
      if (ncs_lo_cnt >= 6) begin
        check("busy_selected", {31'd0, busy}, 32'd1);
        check("miso_oe_selected", {31'd0, miso_oe}, 32'd1);
      end
    end
  end

  // Mode-0 master at SCLK = CLK/8. NCS rises before the final SCLK fall so no trailing load occurs.
  task automatic run_frame(input int abort_bits);
    int         nb, avail, loads, exp_rd, rd0, un0, ov0, exp_ov, nbits;
    logic [7:0] exp_miso[$];
    logic [7:0] got;
    nb     = mosi_q.size();
    avail  = tx_fifo.size();
    loads  = (abort_bits != 0) ? 1 : nb;
    exp_rd = (loads < avail) ? loads : avail;
    for (int i = 0; i < nb; i++) exp_miso.push_back((i < avail) ? tx_fifo[i] : 8'hFF);
    rd0    = n_txrd;
    un0    = n_under;
    ov0    = n_over;
    exp_ov = 0;
    nbits  = (abort_bits != 0) ? abort_bits : 8;
    ncs    = 1'b0;
    repeat (8) @(negedge clk);
    for (int b = 0; b < nb; b++) begin
      rx_full = full_q[b];
      if (abort_bits == 0) begin
        if (full_q[b]) exp_ov++;
        else exp_rx.push_back(mosi_q[b]);
      end
      got = 8'h00;
      for (int k = 0; k < nbits; k++) begin
        mosi = mosi_q[b][7-k];
        repeat (4) @(negedge clk);
        got[7-k] = miso;
        sclk = 1'b1;
        if (k == 7) rise8_cyc = cyc;
        repeat (4) @(negedge clk);
        if (b == nb - 1 && k == nbits - 1 && abort_bits == 0) begin
          ncs = 1'b1;
          repeat (2) @(negedge clk);
        end
        sclk = 1'b0;
      end
      if (abort_bits == 0) check("miso_byte", {24'd0, got}, {24'd0, exp_miso[b]});
      last_miso = got;
    end
    if (abort_bits != 0) begin
      repeat (4) @(negedge clk);
      ncs = 1'b1;
    end
    mosi    = 1'b0;
    rx_full = 1'b0;
    repeat (12) @(negedge clk);
    check("rx_all_written", exp_rx.size(), 32'd0);
    check("tx_rd_count", n_txrd - rd0, exp_rd);
    check("underrun_count", n_under - un0, loads - exp_rd);
    check("overrun_count", n_over - ov0, exp_ov);
    mosi_q.delete();
    full_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_miso"}, {31'd0, miso}, 32'd0);
    check({tag, "_miso_oe"}, {31'd0, miso_oe}, 32'd0);
    check({tag, "_tx_rd"}, {31'd0, tx_rd}, 32'd0);
    check({tag, "_rx_wr"}, {31'd0, rx_wr}, 32'd0);
    check({tag, "_rx_dout"}, {24'd0, rx_dout}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    check({tag, "_underrun"}, {31'd0, underrun}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single byte
    tx_fifo.push_back(8'hA5);
    mosi_q.push_back(8'h3C); full_q.push_back(1'b0);
    repeat (2) @(negedge clk);
    run_frame(0);
    check("single_rx_literal", {24'd0, last_rx}, 32'h3C);
    check("single_miso_literal", {24'd0, last_miso}, 32'hA5);

    // Burst
    tx_fifo.push_back(8'h10); tx_fifo.push_back(8'h20); tx_fifo.push_back(8'h30);
    for (int i = 1; i <= 3; i++) begin
      mosi_q.push_back(8'(i)); full_q.push_back(1'b0);
    end
    repeat (2) @(negedge clk);
    run_frame(0);
    check("burst_rx_literal", {24'd0, last_rx}, 32'h03);
    check("burst_miso_literal", {24'd0, last_miso}, 32'h30);

    // Underrun
    mosi_q.push_back(8'h55); full_q.push_back(1'b0);
    mosi_q.push_back(8'h55); full_q.push_back(1'b0);
    run_frame(0);
    check("underrun_miso_literal", {24'd0, last_miso}, 32'hFF);

    // Overrun
    mosi_q.push_back(8'h77); full_q.push_back(1'b1);
    mosi_q.push_back(8'h88); full_q.push_back(1'b0);
    run_frame(0);
    check("overrun_rx_literal", {24'd0, last_rx}, 32'h88);

    // Abort after 5 bits, then a clean frame
    mosi_q.push_back(8'hAA); full_q.push_back(1'b0);
    run_frame(5);
    check("abort_busy_low", {31'd0, busy}, 32'd0);
    check("abort_no_write", {24'd0, last_rx}, 32'h88);
    mosi_q.push_back(8'hC3); full_q.push_back(1'b0);
    run_frame(0);
    check("abort_next_rx_literal", {24'd0, last_rx}, 32'hC3);

    // Reset in the middle of a frame
    ncs = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      mosi = k[0];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    ncs  = 1'b1;
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    tx_fifo.push_back(8'h5A);
    mosi_q.push_back(8'h96); full_q.push_back(1'b0);
    repeat (2) @(negedge clk);
    run_frame(0);
    check("post_reset_rx_literal", {24'd0, last_rx}, 32'h96);
    check("post_reset_miso_literal", {24'd0, last_miso}, 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
- Synthesizable SPI mode-0 slave, MSB first, 8-bit frames. It is the responder end of the SPI link driven by spi_master.
- NCS, SCLK and MOSI are oversampled in the CLK domain: no SCLK-clocked logic.
- It connects to a TX my_fifo (bytes to send on MISO) and an RX my_fifo (bytes received from MOSI). The host sees a byte-stream device.

Parameters:
- DATA_W, 8, frame width in bits.
- SYNC_STAGES, 2, synchronizer flops on NCS/SCLK/MOSI (minimum 2).
- IDLE_BYTE, 8'hFF, byte shifted out when the TX FIFO is empty.

Ports:
- CLK  in  1  system clock; must be at least 8x the SCLK frequency.
- RST  in  1  asynchronous, active-low reset.
- NCS  in  1  chip select from the master, active-low.
- SCLK  in  1  SPI clock from the master; idles low.
- MOSI  in  1  master-to-slave data.
- MISO  out  1  slave-to-master data.
- MISO_OE  out  1  MISO output enable; high while selected.
- TX_DIN  in  DATA_W  head of the TX FIFO; first-word-fall-through, valid when TX_EMPTY=0.
- TX_EMPTY  in  1  TX FIFO empty.
- TX_RD  out  1  one-cycle pop of the TX FIFO.
- RX_DOUT  out  DATA_W  received byte; valid while RX_WR=1.
- RX_WR  out  1  one-cycle push to the RX FIFO.
- RX_FULL  in  1  RX FIFO full.
- OVERRUN  out  1  one-cycle pulse: a received byte was dropped.
- UNDERRUN  out  1  one-cycle pulse: IDLE_BYTE was substituted for TX data.
- BUSY  out  1  high while a frame is active.

Behaviour:
- Reset (RST=0, asynchronous):
  - All outputs 0 and state IDLE.
  - Bit counter 0, RX shift register 0, TX shift register IDLE_BYTE.
  - Synchronizers preset to NCS=1, SCLK=0.
- Input conditioning:
  - ncs_s, sclk_s, mosi_s are delayed SYNC_STAGES cycles.
  - sclk_rise = sclk_s & ~sclk_q; sclk_fall = ~sclk_s & sclk_q.
  - ncs_fall and ncs_rise are detected the same way.
- States IDLE, SELECT, SHIFT:
  - IDLE -> SELECT on ncs_fall.
  - SELECT lasts exactly 1 cycle, then goes to SHIFT. In SELECT:
    - If TX_EMPTY=0: TX shift register <= TX_DIN and TX_RD pulses.
    - Otherwise: TX shift register <= IDLE_BYTE and UNDERRUN pulses.
  - SHIFT -> IDLE on ncs_rise, from any bit position.
- MISO and MISO_OE:
  - MISO_OE = 1 in SELECT and SHIFT, else 0.
  - MISO = TX shift register MSB when MISO_OE=1, else 0. Registered, no combinational path from the input pins.
- On sclk_rise in SHIFT:
  - RX shift register <= {rx[DATA_W-2:0], mosi_s}; bit counter increments.
  - On the DATA_W-th rise (counter DATA_W-1 -> 0), the next cycle does one of:
    - RX_FULL=0: RX_WR=1, with RX_DOUT holding the assembled byte.
    - RX_FULL=1: byte discarded and OVERRUN=1.
  - RX_FULL is sampled in the completion cycle.
- On sclk_fall in SHIFT:
  - If the counter is non-zero (mid-byte): TX shift register shifts left, filling with 0.
  - If the counter is 0 (byte boundary): load the next byte, using the same TX_EMPTY/IDLE_BYTE/TX_RD/UNDERRUN rule as SELECT.
  - Back-to-back frames therefore run gap-free.
- Timing:
  - RX_WR latency: SYNC_STAGES+2 CLK after the 8th SCLK rising edge at the pin.
  - The master must allow at least SYNC_STAGES+3 CLK from NCS low to the first SCLK rise.
- NCS deasserted mid-byte:
  - Partial RX byte discarded (no RX_WR, no OVERRUN) and counter reset.
  - A TX byte already popped is lost; this is not flagged.
  - BUSY=0 one cycle after ncs_rise is detected.
- Simultaneous events:
  - ncs_rise together with the final sclk_rise: the byte still completes and is written.
  - Rise and fall never occur in the same cycle, given the 8x clock ratio.
- BUSY = (state != IDLE).

Decomposition:
- Package spi_pkg: DATA_W default, IDLE_BYTE default, state enum {IDLE, SELECT, SHIFT}, SYNC_STAGES minimum.
- Sub-module spi_sync_edge: N-stage synchronizer with registered rise/fall outputs and a reset-value parameter.
  - Instanced for NCS and SCLK.
  - MOSI uses its synchronized level only.

Test Plan:
- Single byte:
  - Stimulus: TX FIFO holds 8'hA5; master sends 8'h3C, SCLK = CLK/8.
  - Response: MISO bits 1,0,1,0,0,1,0,1; one RX_WR with RX_DOUT=8'h3C; TX_RD pulses once in SELECT.
- Burst:
  - Stimulus: TX holds 10,20,30; master sends 01,02,03 within one NCS.
  - Response: RX_WR x3 with 01,02,03 in order; MISO carries 10,20,30; TX_RD x3; no UNDERRUN.
- Underrun:
  - Stimulus: TX_EMPTY=1; master sends 8'h55 twice.
  - Response: MISO reads FF,FF; UNDERRUN x2; RX_DOUT 55,55.
- Overrun:
  - Stimulus: RX_FULL=1 across byte 1 (8'h77); RX_FULL=0 for byte 2 (8'h88).
  - Response: byte 1 gives no RX_WR and one OVERRUN pulse; byte 2 gives RX_WR with RX_DOUT=8'h88.
- Abort:
  - Stimulus: NCS rises after 5 bits; a new frame then sends 8'hC3.
  - Response: no RX_WR for the partial byte; BUSY falls; next RX_DOUT=8'hC3, byte-aligned.
- Mid-frame reset:
  - Stimulus: RST=0 at bit 4; released; full frame 8'h96 sent.
  - Response: during reset all outputs 0 immediately; after release RX_DOUT=8'h96 and MISO_OE follows NCS.
